// File: rtl/reg_status_file_pkg.sv
// Shared sizing constants and the tag_map entry layout for the register/status file.
package reg_status_file_pkg;

  localparam int unsigned REG_NUM  = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned TAG_W    = 4;
  // One ROB slot per tag; the ROB uses the same constants.
  localparam int unsigned ROB_SIZE = 1 << TAG_W;

  // Destination register owned by an in-flight ROB tag.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
  } tag_entry_t;

endpackage

// File: rtl/reg_status_file_if.sv
// Dispatch / operand-read / ROB-broadcast / commit bundle of the register status file.
// master = core side (drives dispatch, reads, ROB head); slave = reg_status_file.
interface reg_status_file_if;
  import reg_status_file_pkg::*;

  logic             rdy_in;
  logic             disp_valid;
  logic [REG_W-1:0] disp_rd;
  logic [TAG_W-1:0] disp_tag;
  logic [REG_W-1:0] rs1_idx;
  logic [31:0]      rs1_val;
  logic             rs1_busy;
  logic [TAG_W-1:0] rs1_tag;
  logic [REG_W-1:0] rs2_idx;
  logic [31:0]      rs2_val;
  logic             rs2_busy;
  logic [TAG_W-1:0] rs2_tag;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_val;
  logic             cdb_active;
  logic             predict_fail;
  logic             commit_done;
  logic [REG_W-1:0] commit_rd;
  logic [31:0]      commit_val;

  modport master (
    output rdy_in, disp_valid, disp_rd, disp_tag, rs1_idx, rs2_idx,
    output cdb_tag, cdb_val, cdb_active, predict_fail,
    input  rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag,
    input  commit_done, commit_rd, commit_val
  );

  modport slave (
    input  rdy_in, disp_valid, disp_rd, disp_tag, rs1_idx, rs2_idx,
    input  cdb_tag, cdb_val, cdb_active, predict_fail,
    output rs1_val, rs1_busy, rs1_tag, rs2_val, rs2_busy, rs2_tag,
    output commit_done, commit_rd, commit_val
  );

endinterface

// File: rtl/reg_status_file_read_port.sv
// Combinational operand read: idx -> value / busy / owning tag. x0 always reads as zero.
// Optional COMMIT_BYPASS_EN: forward a same-cycle commit to the reader.
module reg_status_file_read_port
  import reg_status_file_pkg::*;
(
  input  logic [REG_W-1:0]               idx_i,
  input  logic [REG_NUM-1:0][31:0]       regs_i,
  input  logic [REG_NUM-1:0]             busy_i,
  input  logic [REG_NUM-1:0][TAG_W-1:0]  own_tag_i,
  input  logic                           byp_valid_i,
  input  logic [REG_W-1:0]               byp_rd_i,
  input  logic [TAG_W-1:0]               byp_tag_i,
  input  logic [31:0]                    byp_val_i,
  output logic [31:0]                    val_o,
  output logic                           busy_o,
  output logic [TAG_W-1:0]               tag_o
);

`ifndef COMMIT_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_valid_i, byp_rd_i, byp_tag_i, byp_val_i};
`endif

  // Select the architectural state for idx, optionally overridden by the committing value.
  always_comb begin
    val_o  = '0;
    busy_o = 1'b0;
    tag_o  = '0;
    if (idx_i != '0) begin
      val_o  = regs_i[idx_i];
      busy_o = busy_i[idx_i];
      tag_o  = own_tag_i[idx_i];
`ifdef COMMIT_BYPASS_EN
      if (byp_valid_i && (byp_rd_i == idx_i)) begin
        val_o = byp_val_i;
        // Only the youngest owner's commit releases the register.
        if (own_tag_i[idx_i] == byp_tag_i) begin
          busy_o = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file + rename status table fed by the ROB head broadcast.
// Optional feature macro: COMMIT_BYPASS_EN (same-cycle commit forwarding on read ports).
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic          clk_in,
  input  logic          rst_in,
  reg_status_file_if.slave bus
);

  logic [REG_NUM-1:0][31:0]      regs_q, regs_d;
  logic [REG_NUM-1:0]            busy_q, busy_d;
  logic [REG_NUM-1:0][TAG_W-1:0] own_tag_q, own_tag_d;
  tag_entry_t [ROB_SIZE-1:0]     tag_map_q, tag_map_d;
  logic                          commit_done_q, commit_done_d;
  logic [REG_W-1:0]              commit_rd_q, commit_rd_d;
  logic [31:0]                   commit_val_q, commit_val_d;

  tag_entry_t cmt_e;
  logic       byp_valid;

  assign cmt_e     = tag_map_q[bus.cdb_tag];
  assign byp_valid = bus.cdb_active & bus.rdy_in & cmt_e.valid;

  // Next state: commit first, then dispatch (wins on busy/own_tag/tag_map), then flush.
  always_comb begin
    regs_d        = regs_q;
    busy_d        = busy_q;
    own_tag_d     = own_tag_q;
    tag_map_d     = tag_map_q;
    commit_done_d = commit_done_q;
    commit_rd_d   = commit_rd_q;
    commit_val_d  = commit_val_q;
    if (bus.rdy_in) begin
      commit_done_d = 1'b0;
      if (bus.cdb_active) begin
        commit_done_d = 1'b1;
        commit_rd_d   = cmt_e.valid ? cmt_e.rd : '0;
        commit_val_d  = bus.cdb_val;
        if (cmt_e.valid && (cmt_e.rd != '0)) begin
          regs_d[cmt_e.rd] = bus.cdb_val;
        end
        // A younger rename of the same register keeps it busy.
        if (cmt_e.valid && busy_q[cmt_e.rd] && (own_tag_q[cmt_e.rd] == bus.cdb_tag)) begin
          busy_d[cmt_e.rd] = 1'b0;
        end
        tag_map_d[bus.cdb_tag].valid = 1'b0;
      end
      if (bus.disp_valid && !bus.predict_fail) begin
        tag_map_d[bus.disp_tag].valid = 1'b1;
        tag_map_d[bus.disp_tag].rd    = bus.disp_rd;
        if (bus.disp_rd != '0) begin
          busy_d[bus.disp_rd]    = 1'b1;
          own_tag_d[bus.disp_rd] = bus.disp_tag;
        end
      end
      if (bus.predict_fail) begin
        busy_d = '0;
        for (int i = 0; i < ROB_SIZE; i++) begin
          tag_map_d[i].valid = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      regs_q        <= '0;
      busy_q        <= '0;
      own_tag_q     <= '0;
      tag_map_q     <= '0;
      commit_done_q <= 1'b0;
      commit_rd_q   <= '0;
      commit_val_q  <= '0;
    end else begin
      regs_q        <= regs_d;
      busy_q        <= busy_d;
      own_tag_q     <= own_tag_d;
      tag_map_q     <= tag_map_d;
      commit_done_q <= commit_done_d;
      commit_rd_q   <= commit_rd_d;
      commit_val_q  <= commit_val_d;
    end
  end

  assign bus.commit_done = commit_done_q;
  assign bus.commit_rd   = commit_rd_q;
  assign bus.commit_val  = commit_val_q;

  reg_status_file_read_port u_rs1 (
    .idx_i       (bus.rs1_idx),
    .regs_i      (regs_q),
    .busy_i      (busy_q),
    .own_tag_i   (own_tag_q),
    .byp_valid_i (byp_valid),
    .byp_rd_i    (cmt_e.rd),
    .byp_tag_i   (bus.cdb_tag),
    .byp_val_i   (bus.cdb_val),
    .val_o       (bus.rs1_val),
    .busy_o      (bus.rs1_busy),
    .tag_o       (bus.rs1_tag)
  );

  reg_status_file_read_port u_rs2 (
    .idx_i       (bus.rs2_idx),
    .regs_i      (regs_q),
    .busy_i      (busy_q),
    .own_tag_i   (own_tag_q),
    .byp_valid_i (byp_valid),
    .byp_rd_i    (cmt_e.rd),
    .byp_tag_i   (bus.cdb_tag),
    .byp_val_i   (bus.cdb_val),
    .val_o       (bus.rs2_val),
    .busy_o      (bus.rs2_busy),
    .tag_o       (bus.rs2_tag)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed vector table, bypass corner, then random vs model.
module tb_reg_status_file;
  import reg_status_file_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_status_file_if bus_if ();

  reg_status_file dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus_if)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic dv; logic [4:0] drd; logic [3:0] dtag;
    logic ca; logic [3:0] ctag; logic [31:0] cval;
    logic pf; logic rdy;
    logic [4:0] r1; logic [31:0] e1v; logic e1b; logic [3:0] e1t;
    logic [4:0] r2; logic [31:0] e2v; logic e2b; logic [3:0] e2t;
    logic ed; logic [4:0] erd; logic [31:0] ecv;
  } vec_t;

  vec_t vq[$];

  // Reference model state: plain arrays, owner tags as ints.
  logic [31:0] m_reg[REG_NUM];
  bit          m_busy[REG_NUM];
  int          m_own[REG_NUM];
  bit          m_mv[ROB_SIZE];
  int          m_mrd[ROB_SIZE];
  bit          m_done;
  int          m_crd;
  logic [31:0] m_cval;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [4:0] drd, input logic [3:0] dtag,
                       input logic ca, input logic [3:0] ctag, input logic [31:0] cval,
                       input logic pf, input logic rdy, input logic [4:0] r1,
                       input logic [4:0] r2);
    bus_if.disp_valid   = dv;
    bus_if.disp_rd      = drd;
    bus_if.disp_tag     = dtag;
    bus_if.cdb_active   = ca;
    bus_if.cdb_tag      = ctag;
    bus_if.cdb_val      = cval;
    bus_if.predict_fail = pf;
    bus_if.rdy_in       = rdy;
    bus_if.rs1_idx      = r1;
    bus_if.rs2_idx      = r2;
  endtask

  function automatic vec_t mk(
      logic dv, logic [4:0] drd, logic [3:0] dtag, logic ca, logic [3:0] ctag,
      logic [31:0] cval, logic pf, logic rdy,
      logic [4:0] r1, logic [31:0] e1v, logic e1b, logic [3:0] e1t,
      logic [4:0] r2, logic [31:0] e2v, logic e2b, logic [3:0] e2t,
      logic ed, logic [4:0] erd, logic [31:0] ecv);
    vec_t v;
    v.dv = dv; v.drd = drd; v.dtag = dtag; v.ca = ca; v.ctag = ctag; v.cval = cval;
    v.pf = pf; v.rdy = rdy;
    v.r1 = r1; v.e1v = e1v; v.e1b = e1b; v.e1t = e1t;
    v.r2 = r2; v.e2v = e2v; v.e2b = e2b; v.e2t = e2t;
    v.ed = ed; v.erd = erd; v.ecv = ecv;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_reg[i] = '0; m_busy[i] = 0; m_own[i] = 0;
    end
    for (int i = 0; i < ROB_SIZE; i++) begin
      m_mv[i] = 0; m_mrd[i] = 0;
    end
    m_done = 0; m_crd = 0; m_cval = '0;
  endtask

  task automatic m_read(input int idx, input bit ca, input int ctag, input logic [31:0] cval,
                        input bit rdy, output logic [31:0] v, output bit b, output int t);
    v = '0; b = 0; t = 0;
    if (idx != 0) begin
      v = m_reg[idx]; b = m_busy[idx]; t = m_own[idx];
`ifdef COMMIT_BYPASS_EN
      if (ca && rdy && m_mv[ctag] && m_mrd[ctag] == idx) begin
        v = cval;
        if (m_own[idx] == ctag) b = 0;
      end
`endif
    end
  endtask

  // Apply one clock of the architectural rules to the model.
  task automatic model_step(input bit dv, input int drd, input int dtag, input bit ca,
                            input int ctag, input logic [31:0] cval, input bit pf,
                            input bit rdy);
    bit ok;
    int rd;
    if (rdy) begin
      m_done = 0;
      if (ca) begin
        ok = m_mv[ctag];
        rd = m_mrd[ctag];
        if (ok && rd != 0) m_reg[rd] = cval;
        if (ok && m_busy[rd] && m_own[rd] == ctag) m_busy[rd] = 0;
        m_mv[ctag] = 0;
        m_done = 1;
        m_crd  = ok ? rd : 0;
        m_cval = cval;
      end
      if (dv && !pf) begin
        m_mv[dtag]  = 1;
        m_mrd[dtag] = drd;
        if (drd != 0) begin
          m_busy[drd] = 1;
          m_own[drd]  = dtag;
        end
      end
      if (pf) begin
        for (int i = 0; i < REG_NUM; i++) m_busy[i] = 0;
        for (int i = 0; i < ROB_SIZE; i++) m_mv[i] = 0;
      end
    end
  endtask

  vec_t        v;
  logic        dv, ca, pf, rdy;
  logic [4:0]  drd, r1, r2;
  logic [3:0]  dtag, ctag;
  logic [31:0] cval, ev;
  bit          eb;
  int          et;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset commit_done", 32'(bus_if.commit_done), 0);
    chk("reset commit_rd", 32'(bus_if.commit_rd), 0);
    chk("reset commit_val", bus_if.commit_val, 0);

    //       dv drd dtag ca ctag cval pf rdy | r1 e1v e1b e1t | r2 e2v e2b e2t | ed erd ecv
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  5, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 5, 3,  0, 0, 0, 0, 1,  5, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  5, 0, 1, 3,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 3, 32'hDEADBEEF, 0, 1,  7, 0, 0, 0,  0, 0, 0, 0,
                    1, 5, 32'hDEADBEEF));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  5, 32'hDEADBEEF, 0, 3,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 7, 1,  0, 0, 0, 0, 1,  7, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 7, 2,  0, 0, 0, 0, 1,  7, 0, 1, 1,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 1, 32'h11, 0, 1,  5, 32'hDEADBEEF, 0, 3,  0, 0, 0, 0,
                    1, 7, 32'h11));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  7, 32'h11, 1, 2,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 2, 32'h22, 0, 1,  5, 32'hDEADBEEF, 0, 3,  0, 0, 0, 0,
                    1, 7, 32'h22));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  7, 32'h22, 0, 2,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 9, 4,  0, 0, 0, 0, 1,  9, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 10, 5, 0, 0, 0, 0, 1,  9, 0, 1, 4,  0, 0, 0, 0,  0, 0, 0));
    // predict_fail with same-cycle commit; the dispatch of rd 11 must be dropped
    vq.push_back(mk(1, 11, 7, 1, 4, 32'h44, 1, 1,  10, 0, 1, 5,  0, 0, 0, 0,  1, 9, 32'h44));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  9, 32'h44, 0, 4,  10, 0, 0, 5,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 5, 32'h55, 0, 1,  11, 0, 0, 0,  10, 0, 0, 5,  1, 0, 32'h55));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  10, 0, 0, 5,  11, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 0, 6,  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 6, 32'h99, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 32'h99));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    // rdy_in low during a commit
    vq.push_back(mk(1, 12, 8, 0, 0, 0, 0, 1,  12, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  12, 0, 1, 8,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 8, 32'hAA, 0, 0,  12, 0, 1, 8,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 0,  12, 0, 1, 8,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 8, 32'hAA, 0, 1,  13, 0, 0, 0,  0, 0, 0, 0,  1, 12, 32'hAA));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  12, 32'hAA, 0, 8,  0, 0, 0, 0,  0, 0, 0));
    // commit of a retired tag, then a stall must hold the pulse
    vq.push_back(mk(0, 0, 0,  1, 8, 32'hBB, 0, 1,  12, 32'hAA, 0, 8,  0, 0, 0, 0,
                    1, 0, 32'hBB));
    vq.push_back(mk(1, 16, 11, 0, 0, 0, 0, 0,  16, 0, 0, 0,  0, 0, 0, 0,  1, 0, 32'hBB));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  16, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    // same-rd dispatch+commit, then tag reuse
    vq.push_back(mk(1, 14, 9, 0, 0, 0, 0, 1,  14, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 14, 10, 1, 9, 32'h14, 0, 1,  13, 0, 0, 0,  0, 0, 0, 0,
                    1, 14, 32'h14));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  14, 32'h14, 1, 10,  0, 0, 0, 0,  0, 0, 0));
    vq.push_back(mk(1, 15, 10, 1, 10, 32'h15, 0, 1,  13, 0, 0, 0,  0, 0, 0, 0,
                    1, 14, 32'h15));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  14, 32'h15, 0, 10,  15, 0, 1, 10,  0, 0, 0));
    vq.push_back(mk(0, 0, 0,  1, 10, 32'h16, 0, 1,  13, 0, 0, 0,  0, 0, 0, 0,
                    1, 15, 32'h16));
    vq.push_back(mk(0, 0, 0,  0, 0, 0, 0, 1,  15, 32'h16, 0, 10,  0, 0, 0, 0,  0, 0, 0));

    foreach (vq[i]) begin
      v = vq[i];
      drive(v.dv, v.drd, v.dtag, v.ca, v.ctag, v.cval, v.pf, v.rdy, v.r1, v.r2);
      #1;
      chk($sformatf("v%0d rs1_val", i), bus_if.rs1_val, v.e1v);
      chk($sformatf("v%0d rs1_busy", i), 32'(bus_if.rs1_busy), 32'(v.e1b));
      chk($sformatf("v%0d rs1_tag", i), 32'(bus_if.rs1_tag), 32'(v.e1t));
      chk($sformatf("v%0d rs2_val", i), bus_if.rs2_val, v.e2v);
      chk($sformatf("v%0d rs2_busy", i), 32'(bus_if.rs2_busy), 32'(v.e2b));
      chk($sformatf("v%0d rs2_tag", i), 32'(bus_if.rs2_tag), 32'(v.e2t));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d commit_done", i), 32'(bus_if.commit_done), 32'(v.ed));
      if (v.ed) begin
        chk($sformatf("v%0d commit_rd", i), 32'(bus_if.commit_rd), 32'(v.erd));
        chk($sformatf("v%0d commit_val", i), bus_if.commit_val, v.ecv);
      end
    end

    // Same-cycle read of a committing register.
    drive(1, 5, 3, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 3, 32'hABCD, 0, 1, 5, 0);
    #1;
`ifdef COMMIT_BYPASS_EN
    chk("bypass rs1_val", bus_if.rs1_val, 32'hABCD);
    chk("bypass rs1_busy", 32'(bus_if.rs1_busy), 0);
`else
    chk("nobypass rs1_val", bus_if.rs1_val, 32'hDEADBEEF);
    chk("nobypass rs1_busy", 32'(bus_if.rs1_busy), 1);
`endif
    chk("bypass rs1_tag", 32'(bus_if.rs1_tag), 3);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);
    #1;
    chk("after bypass rs1_val", bus_if.rs1_val, 32'hABCD);
    chk("after bypass rs1_busy", 32'(bus_if.rs1_busy), 0);
    chk("after bypass commit_rd", 32'(bus_if.commit_rd), 5);

    // Randomised run against the reference model.
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      dv   = 1'($urandom_range(0, 1));
      drd  = 5'($urandom_range(0, 7));
      dtag = 4'($urandom_range(0, 15));
      ca   = ($urandom_range(0, 9) < 4);
      ctag = 4'($urandom_range(0, 15));
      cval = $urandom;
      pf   = ($urandom_range(0, 31) == 0);
      rdy  = ($urandom_range(0, 9) != 0);
      r1   = 5'($urandom_range(0, 7));
      r2   = 5'($urandom_range(0, 7));
      drive(dv, drd, dtag, ca, ctag, cval, pf, rdy, r1, r2);
      #1;
      m_read(int'(r1), ca, int'(ctag), cval, rdy, ev, eb, et);
      chk($sformatf("rnd%0d rs1_val", n), bus_if.rs1_val, ev);
      chk($sformatf("rnd%0d rs1_busy", n), 32'(bus_if.rs1_busy), 32'(eb));
      chk($sformatf("rnd%0d rs1_tag", n), 32'(bus_if.rs1_tag), 32'(et));
      m_read(int'(r2), ca, int'(ctag), cval, rdy, ev, eb, et);
      chk($sformatf("rnd%0d rs2_val", n), bus_if.rs2_val, ev);
      chk($sformatf("rnd%0d rs2_busy", n), 32'(bus_if.rs2_busy), 32'(eb));
      chk($sformatf("rnd%0d rs2_tag", n), 32'(bus_if.rs2_tag), 32'(et));
      @(posedge clk);
      #1;
      model_step(dv, int'(drd), int'(dtag), ca, int'(ctag), cval, pf, rdy);
      chk($sformatf("rnd%0d commit_done", n), 32'(bus_if.commit_done), 32'(m_done));
      if (m_done) begin
        chk($sformatf("rnd%0d commit_rd", n), 32'(bus_if.commit_rd), 32'(m_crd));
        chk($sformatf("rnd%0d commit_val", n), bus_if.commit_val, m_cval);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
